wreg_hazard_pipe: RTL

//  Consumes the destination-register number chosen by the ID-stage 5-bit 4:1 write-register mux.

---
 rtl/wreg_hazard_pipe_if.sv | 35 +++
 rtl/wreg_hazard_pipe.sv | 84 ++++++++
 2 files changed

// File: rtl/wreg_hazard_pipe_if.sv
// Hazard-pipe bus: control and ID-stage operand/destination fields in,
// forwarding selects, stall request and stage destinations out.
interface wreg_hazard_pipe_if #(
  parameter int unsigned AW = 5
);
  logic          i_hold;
  logic          i_flush;
  logic [AW-1:0] i_id_wreg;
  logic          i_id_regwrite;
  logic          i_id_memread;
  logic [AW-1:0] i_id_rs;
  logic [AW-1:0] i_id_rt;
  logic          i_id_rt_used;
  logic [1:0]    o_fwd_a;
  logic [1:0]    o_fwd_b;
  logic          o_load_use_stall;
  logic [AW-1:0] o_ex_wreg;
  logic [AW-1:0] o_mem_wreg;
  logic [AW-1:0] o_wb_wreg;
  logic          o_wb_regwrite;

  modport slave (
    input  i_hold, i_flush, i_id_wreg, i_id_regwrite, i_id_memread,
           i_id_rs, i_id_rt, i_id_rt_used,
    output o_fwd_a, o_fwd_b, o_load_use_stall, o_ex_wreg, o_mem_wreg,
           o_wb_wreg, o_wb_regwrite
  );

  modport master (
    output i_hold, i_flush, i_id_wreg, i_id_regwrite, i_id_memread,
           i_id_rs, i_id_rt, i_id_rt_used,
    input  o_fwd_a, o_fwd_b, o_load_use_stall, o_ex_wreg, o_mem_wreg,
           o_wb_wreg, o_wb_regwrite
  );
endinterface

// File: rtl/wreg_hazard_pipe.sv
// Purpose: carry the destination register through EX/MEM/WB; derive forwarding, load-use stall, WB write.
// Latency: id_wreg -> ex_wreg 1 cycle, mem_wreg 2, wb_wreg 3; stall and forward selects are combinational.
// Backpressure: i_hold freezes every stage; a load-use stall holds ID upstream and inserts one EX bubble.
module wreg_hazard_pipe #(
  parameter int unsigned AW        = 5,
  parameter bit          ZERO_WIRE = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  wreg_hazard_pipe_if.slave bus
);

  typedef struct packed {
    logic [AW-1:0] wreg;
    logic          regwrite;
  } stage_t;

  typedef struct packed {
    logic [AW-1:0] wreg;
    logic          regwrite;
    logic          memread;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } ex_t;

  ex_t    r_ex;
  stage_t r_mem;
  stage_t r_wb;

  logic   w_eff_rw;
  logic   w_stall;
  logic   w_bubble;

  // Writes to a hard-wired r0 are dropped at capture so no later stage can match on them.
  assign w_eff_rw = bus.i_id_regwrite & (ZERO_WIRE ? (|bus.i_id_wreg) : 1'b1);

  assign w_stall = r_ex.memread & r_ex.regwrite &
                   ((r_ex.wreg == bus.i_id_rs) |
                    (bus.i_id_rt_used & (r_ex.wreg == bus.i_id_rt)));

  assign w_bubble = bus.i_flush | w_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.i_hold) begin
      r_wb           <= r_mem;
      r_mem.wreg     <= r_ex.wreg;
      r_mem.regwrite <= r_ex.regwrite;
      if (w_bubble) begin
        r_ex <= '0;
      end else begin
        r_ex.wreg     <= bus.i_id_wreg;
        r_ex.regwrite <= w_eff_rw;
        r_ex.memread  <= bus.i_id_memread;
        r_ex.rs       <= bus.i_id_rs;
        r_ex.rt       <= bus.i_id_rt;
      end
    end
  end

  // MEM holds the younger result, so it is checked before WB.
  always_comb begin
    bus.o_fwd_a = 2'b00;
    bus.o_fwd_b = 2'b00;
    if (r_mem.regwrite && (r_mem.wreg == r_ex.rs))
      bus.o_fwd_a = 2'b01;
    else if (r_wb.regwrite && (r_wb.wreg == r_ex.rs))
      bus.o_fwd_a = 2'b10;
    if (r_mem.regwrite && (r_mem.wreg == r_ex.rt))
      bus.o_fwd_b = 2'b01;
    else if (r_wb.regwrite && (r_wb.wreg == r_ex.rt))
      bus.o_fwd_b = 2'b10;
  end

  assign bus.o_load_use_stall = w_stall;
  assign bus.o_ex_wreg        = r_ex.wreg;
  assign bus.o_mem_wreg       = r_mem.wreg;
  assign bus.o_wb_wreg        = r_wb.wreg;
  assign bus.o_wb_regwrite    = r_wb.regwrite;

endmodule
